keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix hex keypad: drives one active-low column at a time, samples the active-low row lines, debounces both press and release, and emits one registered 4-bit hex code per debounced keypress. It is the input-side counterpart to the `sevseg` display path. Its `key_code` output feeds the display and LED logic in the top level, which is clocked from the HSOSC-derived 24 MHz clock.

## Interface
- `SCAN_CYCLES`, default 2400: column dwell in clocks (100 us at 24 MHz). Must be ≥ 4.
- `DEBOUNCE_CYCLES`, default 480000: press/release stable time in clocks (20 ms at 24 MHz). Must be ≥ 2.
- `clk`  in  1: single clock, 24 MHz nominal.
- `reset`  in  1: asynchronous, active-low reset.
- `rows`  in  4: keypad rows. Asynchronous, externally pulled up; low = key closed in the driven column.
- `cols`  out  4: column drives, active-low. Exactly one bit is low at all times.
- `key_code`  out  4: hex value of the last debounced key. Holds until the next press.
- `key_valid`  out  1: one-cycle pulse when a new `key_code` is loaded.
- `key_held`  out  1: high from `key_valid` until release debounce completes.

## Operation
- `rows` passes through a 2-FF synchronizer. All decisions use the synchronized value `rs`.
- Column index `c` is 0..3 and `cols = ~(4'b1 << c)`.
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - The dwell counter runs 0..SCAN_CYCLES-1.
  - `rs` is sampled only when the counter equals SCAN_CYCLES-1.
  - If any `rs` bit is low: latch row `r` (lowest low index wins), keep `c`, clear the debounce counter, go to PRESS_DB.
  - Otherwise: `c` advances (3 wraps to 0) and the dwell counter clears.
- PRESS_DB:
  - `c` is frozen.
  - While `rs[r]` is low, the counter increments.
  - If `rs[r]` goes high before the count completes: go to SCAN, advance `c`, clear dwell. No output change.
  - At count DEBOUNCE_CYCLES-1 with `rs[r]` still low, on the next edge: load `key_code`, pulse `key_valid`, set `key_held`, go to HELD.
- HELD:
  - `c` is frozen and only `rs[r]` is watched. Other keys are ignored, including other rows in the same column.
  - When `rs[r]` goes high: clear the counter and go to RELEASE_DB.
- RELEASE_DB:
  - Counts while `rs[r]` is high.
  - If `rs[r]` goes low again: return to HELD with no new pulse.
  - At count DEBOUNCE_CYCLES-1 with `rs[r]` high: clear `key_held`, advance `c`, clear dwell, go to SCAN.
- Counter widths are `$clog2` of the respective parameter. Counters never exceed their terminal value.
- Reset (asynchronous, any state) forces:
  - state SCAN, `c` = 0, `cols` = 4'b1110
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0
  - counters 0, synchronizer FFs all 1s

## Timing
- All outputs are registered. No combinational path from `rows` to any output.
- Row-edge-to-decision latency is 2 clocks (synchronizer).
- Press to `key_valid`, for a key in the currently driven column:
  - best case: 2 + 1 + DEBOUNCE_CYCLES clocks
  - worst case: adds 4·SCAN_CYCLES for a full column rotation
- `key_valid` is high for exactly one cycle per debounced press and never repeats while held.
- `key_code` changes only in the same cycle `key_valid` is high.
- `key_held` deasserts DEBOUNCE_CYCLES+3 clocks after a clean release (2 synchronizer clocks + count + transition edge).
- Scanning resumes on the column after the released one.
- Bounce shorter than the debounce window restarts nothing. It aborts the press or cancels the release as described above.

## Test plan
Bench uses SCAN_CYCLES=4, DEBOUNCE_CYCLES=8 and a keypad model that pulls `rows[r]` low when `cols[c]` is low and key (r,c) is closed.
- Reset and idle:
  - Assert reset with no keys pressed → `cols` = 1110, outputs 0.
  - Release reset → `cols` steps 1110→1101→1011→0111→1110, changing every 4 clocks.
- Clean press of key (r1,c2) held 40 clocks → exactly one `key_valid` pulse with `key_code` = 4'h6, `key_held` = 1.
  - `cols` stays 1011 until 11 clocks after release, then `key_held` = 0 and `cols` = 0111.
- Press bounce: (r3,c1) low 3 clocks, high 2, low 30 → a single `key_valid` with `key_code` = 4'h0, only after a full 8-clock stable window.
  - A 3-clock-only glitch alone → no `key_valid`.
- Release bounce: while (r0,c3) is held (`key_code` = 4'hA), release 4 clocks then re-close → no second pulse, `key_held` stays 1.
  - Final release → `key_held` falls.
- Simultaneous keys:
  - (r0,c0) and (r2,c0) closed together → `key_code` = 4'h1.
  - While held, also closing (r1,c3) → ignored.
  - After (r0,c0) release, the scan reaches c3 → `key_code` = 4'hB.
- Reset mid-operation: assert reset during PRESS_DB and again during HELD → immediate `cols` = 1110, `key_held` = 0, `key_code` = 0.
  - No `key_valid` is produced until a full new debounce completes.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low column strobe, synchronizes the
// active-low rows, debounces press and release, and emits one code per keypress.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 2400,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t          r_state;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [1:0]      r_col;
    logic [3:0]      r_cols;
    logic [1:0]      r_row;
    logic [DW-1:0]   r_dwell;
    logic [BW-1:0]   r_db;
    logic [3:0]      r_key_code;
    logic            r_key_valid;
    logic            r_key_held;

    logic            w_any_low;
    logic            w_row_low;
    logic [1:0]      w_low_idx;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_lookup = 4'h1;
            4'h1: key_lookup = 4'h2;
            4'h2: key_lookup = 4'h3;
            4'h3: key_lookup = 4'hA;
            4'h4: key_lookup = 4'h4;
            4'h5: key_lookup = 4'h5;
            4'h6: key_lookup = 4'h6;
            4'h7: key_lookup = 4'hB;
            4'h8: key_lookup = 4'h7;
            4'h9: key_lookup = 4'h8;
            4'hA: key_lookup = 4'h9;
            4'hB: key_lookup = 4'hC;
            4'hC: key_lookup = 4'hE;
            4'hD: key_lookup = 4'h0;
            4'hE: key_lookup = 4'hF;
            default: key_lookup = 4'hD;
        endcase
    endfunction

    assign w_any_low = ~&r_sync2;
    assign w_row_low = ~r_sync2[r_row];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_low_idx = 2'd0;
        if (!r_sync2[0])      w_low_idx = 2'd0;
        else if (!r_sync2[1]) w_low_idx = 2'd1;
        else if (!r_sync2[2]) w_low_idx = 2'd2;
        else if (!r_sync2[3]) w_low_idx = 2'd3;
    end

    // Rows idle high, so the synchronizer resets to all ones to avoid a phantom press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments keep the two stages as distinct flops.
            r_sync1 <= rows;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SCAN;
            r_col       <= 2'd0;
            r_cols      <= 4'b1110;
            r_row       <= 2'd0;
            r_dwell     <= '0;
            r_db        <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        if (w_any_low) begin
                            r_row   <= w_low_idx;
                            r_db    <= '0;
                            r_state <= PRESS_DB;
                        end else begin
                            r_col   <= r_col + 2'd1;
                            r_cols  <= {r_cols[2:0], r_cols[3]};
                            r_dwell <= '0;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!w_row_low) begin
                        r_col   <= r_col + 2'd1;
                        r_cols  <= {r_cols[2:0], r_cols[3]};
                        r_dwell <= '0;
                        r_state <= SCAN;
                    end else if (r_db == DB_LAST) begin
                        r_key_code  <= key_lookup(r_row, r_col);
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_state     <= HELD;
                    end else begin
                        r_db <= r_db + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_row_low) begin
                        r_db    <= '0;
                        r_state <= RELEASE_DB;
                    end
                end
                default: begin
                    if (w_row_low) begin
                        r_state <= HELD;
                    end else if (r_db == DB_LAST) begin
                        r_key_held <= 1'b0;
                        r_col      <= r_col + 2'd1;
                        r_cols     <= {r_cols[2:0], r_cols[3]};
                        r_dwell    <= '0;
                        r_state    <= SCAN;
                    end else begin
                        r_db <= r_db + 1'b1;
                    end
                end
            endcase
        end
    end

    assign cols      = r_cols;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model (SCAN=4, DEBOUNCE=8).
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;   // bit r*4+c closes key (r,c)

    int n_checks;
    int n_errors;
    int cyc;
    int pulse_count;
    int last_pulse_cyc;
    logic [3:0] last_pulse_code;
    int code_glitches;
    logic [3:0] prev_code;
    logic prev_rst;

    keypad_scanner #(
        .SCAN_CYCLES(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    // Pulse and code-stability monitor, sampled just after each rising edge.
    initial begin
        cyc = 0; pulse_count = 0; last_pulse_cyc = 0; last_pulse_code = 4'h0;
        code_glitches = 0; prev_code = 4'h0; prev_rst = 1'b0;
    end
    always @(posedge clk) begin
        #1;
        cyc++;
        if (key_valid) begin
            pulse_count++;
            last_pulse_cyc = cyc;
            last_pulse_code = key_code;
        end
        if (reset && prev_rst && key_code !== prev_code && !key_valid) code_glitches++;
        prev_code = key_code;
        prev_rst = reset;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (key_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_held_low(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (!key_held) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_cols;
        reset = 1'b0;
        keys = 16'h0;
        step(3);
        n_checks++;
        if (cols !== 4'b1110) begin n_errors++; $display("FAIL reset_cols: got %b expected 1110", cols); end
        n_checks++;
        if ({key_code, key_valid, key_held} !== 6'b0) begin
            n_errors++; $display("FAIL reset_outputs: got code=%h valid=%b held=%b expected 0 0 0", key_code, key_valid, key_held);
        end
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            exp_cols = ~(4'b0001 << ((i / 4) % 4));
            n_checks++;
            if (cols !== exp_cols) begin
                n_errors++; $display("FAIL idle_scan_cycle%0d: got %b expected %b", i, cols, exp_cols);
            end
        end
    endtask

    task automatic test_clean_press;
        int p0;
        logic ok;
        p0 = pulse_count;
        keys[6] = 1'b1;
        step(40);
        n_checks++;
        if (pulse_count - p0 !== 1) begin n_errors++; $display("FAIL clean_pulses: got %0d expected 1", pulse_count - p0); end
        n_checks++;
        if (last_pulse_code !== 4'h6) begin n_errors++; $display("FAIL clean_code: got %h expected 6", last_pulse_code); end
        n_checks++;
        if (key_held !== 1'b1 || cols !== 4'b1011) begin
            n_errors++; $display("FAIL clean_held: got held=%b cols=%b expected 1 1011", key_held, cols);
        end
        keys[6] = 1'b0;
        ok = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (key_held !== 1'b1 || cols !== 4'b1011) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL clean_release_early: got held/cols change before 11 clocks expected none"); end
        step(1);
        n_checks++;
        if (key_held !== 1'b0 || cols !== 4'b0111) begin
            n_errors++; $display("FAIL clean_release_11: got held=%b cols=%b expected 0 0111", key_held, cols);
        end
        n_checks++;
        if (pulse_count - p0 !== 1) begin n_errors++; $display("FAIL clean_no_repeat: got %0d expected 1", pulse_count - p0); end
    endtask

    task automatic test_press_bounce;
        int p0;
        int start;
        logic seen;
        p0 = pulse_count;
        keys[13] = 1'b1; step(3);
        keys[13] = 1'b0; step(2);
        keys[13] = 1'b1; start = cyc;
        step(35);
        n_checks++;
        if (pulse_count - p0 !== 1) begin n_errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulse_count - p0); end
        n_checks++;
        if (last_pulse_code !== 4'h0) begin n_errors++; $display("FAIL bounce_code: got %h expected 0", last_pulse_code); end
        n_checks++;
        if (last_pulse_cyc - start < 11 || last_pulse_cyc - start > 27) begin
            n_errors++; $display("FAIL bounce_latency: got %0d expected 11..27", last_pulse_cyc - start);
        end
        keys[13] = 1'b0;
        wait_held_low(30, seen);
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL bounce_release: got held=1 expected 0 within 30 clocks"); end
        p0 = pulse_count;
        keys[13] = 1'b1; step(3);
        keys[13] = 1'b0; step(30);
        n_checks++;
        if (pulse_count - p0 !== 0) begin n_errors++; $display("FAIL glitch_only: got %0d pulses expected 0", pulse_count - p0); end
    endtask

    task automatic test_release_bounce;
        int p0;
        int low_cycles;
        logic seen;
        logic ok;
        keys[3] = 1'b1;
        wait_valid(40, seen);
        n_checks++;
        if (!seen || key_code !== 4'hA) begin
            n_errors++; $display("FAIL relb_press: got seen=%b code=%h expected 1 A", seen, key_code);
        end
        p0 = pulse_count;
        step(5);
        keys[3] = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 4; i++) begin step(1); if (!key_held) low_cycles++; end
        keys[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin step(1); if (!key_held) low_cycles++; end
        n_checks++;
        if (low_cycles !== 0) begin n_errors++; $display("FAIL relb_held: got %0d low cycles expected 0", low_cycles); end
        n_checks++;
        if (pulse_count - p0 !== 0) begin n_errors++; $display("FAIL relb_no_repulse: got %0d expected 0", pulse_count - p0); end
        keys[3] = 1'b0;
        ok = 1'b1;
        for (int i = 1; i <= 10; i++) begin step(1); if (key_held !== 1'b1) ok = 1'b0; end
        step(1);
        n_checks++;
        if (!ok || key_held !== 1'b0) begin
            n_errors++; $display("FAIL relb_final: got early=%b held=%b expected 1 0", !ok, key_held);
        end
    endtask

    task automatic test_simultaneous;
        int p0;
        logic seen;
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        wait_valid(40, seen);
        n_checks++;
        if (!seen || key_code !== 4'h1) begin
            n_errors++; $display("FAIL simul_priority: got seen=%b code=%h expected 1 1", seen, key_code);
        end
        p0 = pulse_count;
        keys[7] = 1'b1;
        step(20);
        n_checks++;
        if (pulse_count - p0 !== 0 || key_code !== 4'h1 || key_held !== 1'b1) begin
            n_errors++; $display("FAIL simul_ignore: got pulses=%0d code=%h held=%b expected 0 1 1", pulse_count - p0, key_code, key_held);
        end
        keys[0] = 1'b0;
        wait_valid(60, seen);
        n_checks++;
        if (!seen || key_code !== 4'hB) begin
            n_errors++; $display("FAIL simul_next: got seen=%b code=%h expected 1 B", seen, key_code);
        end
        keys = 16'h0;
        wait_held_low(30, seen);
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL simul_release: got held=1 expected 0 within 30 clocks"); end
        step(4);
    endtask

    task automatic reset_and_check(input string tag);
        reset = 1'b0;
        #1;
        n_checks++;
        if (cols !== 4'b1110 || key_held !== 1'b0 || key_code !== 4'h0 || key_valid !== 1'b0) begin
            n_errors++; $display("FAIL %s: got cols=%b held=%b code=%h valid=%b expected 1110 0 0 0", tag, cols, key_held, key_code, key_valid);
        end
    endtask

    task automatic expect_valid_at_12(input string tag);
        logic early;
        early = 1'b0;
        reset = 1'b1;
        for (int i = 1; i <= 11; i++) begin step(1); if (key_valid) early = 1'b1; end
        step(1);
        n_checks++;
        if (early || key_valid !== 1'b1 || key_code !== 4'h4 || key_held !== 1'b1) begin
            n_errors++; $display("FAIL %s: got early=%b valid=%b code=%h held=%b expected 0 1 4 1", tag, early, key_valid, key_code, key_held);
        end
    endtask

    task automatic test_reset_midop;
        logic early;
        logic seen;
        step(1);
        keys[4] = 1'b1;
        reset_and_check("midop_reset_from_idle");
        step(2);
        reset = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin step(1); if (key_valid) early = 1'b1; end
        n_checks++;
        if (early) begin n_errors++; $display("FAIL midop_early_valid: got 1 expected 0"); end
        reset_and_check("midop_reset_press_db");
        step(2);
        expect_valid_at_12("midop_after_press_db");
        step(3);
        reset_and_check("midop_reset_held");
        step(2);
        expect_valid_at_12("midop_after_held");
        keys = 16'h0;
        wait_held_low(30, seen);
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL midop_release: got held=1 expected 0 within 30 clocks"); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        keys = 16'h0;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_midop();
        n_checks++;
        if (code_glitches !== 0) begin
            n_errors++; $display("FAIL code_stability: got %0d changes without key_valid expected 0", code_glitches);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
